gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 78 +++++++
 tb/tb_gray_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view, plus an independent
// one-cycle Gray-to-binary converter. All state resets synchronously.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    input  logic             g_valid_in,
    input  logic [WIDTH-1:0] gray_in,
    output logic             b_valid_out,
    output logic [WIDTH-1:0] bin_conv_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] bin_nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] g2b;

    // Load beats count; wrap is only raised by a counting step across the end.
    always_comb begin
        bin_nxt  = bin_out;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_bin;
        end else if (en) begin
            if (up_dn) begin
                bin_nxt  = bin_out + ONE;
                wrap_nxt = (bin_out == MAX);
            end else begin
                bin_nxt  = bin_out - ONE;
                wrap_nxt = (bin_out == '0);
            end
        end
    end

    // Gray is derived from the next binary value so both registers move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= bin_nxt;
            gray_out <= bin_nxt ^ (bin_nxt >> 1);
            wrap     <= wrap_nxt;
        end
    end

    always_comb begin
        g2b            = '0;
        g2b[WIDTH-1]   = gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            g2b[i] = g2b[i+1] ^ gray_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid_out  <= 1'b0;
            bin_conv_out <= '0;
        end else begin
            b_valid_out <= g_valid_in;
            if (g_valid_in) begin
                bin_conv_out <= g2b;
            end
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Drives WIDTH=2/4/8 instances from shared stimulus; a modulo-arithmetic model
// is compared every cycle, with literal expectations pinning the WIDTH=4 case.
module tb_gray_counter;

    logic        clk = 1'b0;
    logic        rst, en, up_dn, load, g_valid_in;
    logic [15:0] load_bin, gray_in;

    logic [1:0] bo2, go2, bc2;
    logic [3:0] bo4, go4, bc4;
    logic [7:0] bo8, go8, bc8;
    logic       wr2, wr4, wr8, bv2, bv4, bv8;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin[1:0]), .bin_out(bo2), .gray_out(go2), .wrap(wr2),
        .g_valid_in(g_valid_in), .gray_in(gray_in[1:0]), .b_valid_out(bv2), .bin_conv_out(bc2));
    gray_counter #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin[3:0]), .bin_out(bo4), .gray_out(go4), .wrap(wr4),
        .g_valid_in(g_valid_in), .gray_in(gray_in[3:0]), .b_valid_out(bv4), .bin_conv_out(bc4));
    gray_counter #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin[7:0]), .bin_out(bo8), .gray_out(go8), .wrap(wr8),
        .g_valid_in(g_valid_in), .gray_in(gray_in[7:0]), .b_valid_out(bv8), .bin_conv_out(bc8));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Inverse Gray by exhaustive search: the binary whose Gray code matches.
    function automatic int gray_inv(input int g, input int w);
        for (int b = 0; b < (1 << w); b++)
            if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    int wid[3] = '{2, 4, 8};
    int m_bin[3], m_wrap[3], m_bv[3], m_bc[3], m_step[3], prev_gray[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int m;
            m = 1 << wid[k];
            m_step[k] = 0;
            if (rst) begin
                m_bin[k] = 0; m_wrap[k] = 0; m_bv[k] = 0; m_bc[k] = 0;
            end else begin
                m_wrap[k] = 0;
                if (load) begin
                    m_bin[k] = int'(load_bin) % m;
                end else if (en) begin
                    m_step[k] = 1;
                    if (up_dn) begin
                        m_wrap[k] = (m_bin[k] == m - 1) ? 1 : 0;
                        m_bin[k]  = (m_bin[k] + 1) % m;
                    end else begin
                        m_wrap[k] = (m_bin[k] == 0) ? 1 : 0;
                        m_bin[k]  = (m_bin[k] + m - 1) % m;
                    end
                end
                m_bv[k] = g_valid_in ? 1 : 0;
                if (g_valid_in) m_bc[k] = gray_inv(int'(gray_in) % m, wid[k]);
            end
        end
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                int ab, ag, aw, av, ac;
                case (k)
                    0: begin ab = bo2; ag = go2; aw = wr2; av = bv2; ac = bc2; end
                    1: begin ab = bo4; ag = go4; aw = wr4; av = bv4; ac = bc4; end
                    default: begin ab = bo8; ag = go8; aw = wr8; av = bv8; ac = bc8; end
                endcase
                chk($sformatf("w%0d_bin", wid[k]), ab, m_bin[k]);
                chk($sformatf("w%0d_gray", wid[k]), ag, m_bin[k] ^ (m_bin[k] >> 1));
                chk($sformatf("w%0d_wrap", wid[k]), aw, m_wrap[k]);
                chk($sformatf("w%0d_bvalid", wid[k]), av, m_bv[k]);
                chk($sformatf("w%0d_bconv", wid[k]), ac, m_bc[k]);
                if (m_step[k] != 0)
                    chk($sformatf("w%0d_onebit", wid[k]), $countones(ag ^ prev_gray[k]), 1);
                prev_gray[k] = ag;
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input int lb, input logic gv, input int gi);
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l;
        load_bin = lb[15:0]; g_valid_in = gv; gray_in = gi[15:0];
        @(posedge clk);
        #1;
    endtask

    int seq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_bin = '0; g_valid_in = 1'b0; gray_in = '0;
        drive(1, 1, 1, 1, 5, 1, 3);
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("rst_bin", bo4, 0);
        chk("rst_gray", go4, 0);
        chk("rst_wrap", wr4, 0);
        chk("rst_bvalid", bv4, 0);

        // full up period; 256 steps returns all widths to zero
        for (int i = 0; i < 256; i++) begin
            drive(0, 1, 1, 0, 0, 0, 0);
            if (i < 16) begin
                chk("up_seq_gray", go4, seq[i+1]);
                chk("up_seq_wrap", wr4, (i == 15) ? 1 : 0);
            end
        end

        drive(0, 1, 0, 0, 0, 0, 0);
        chk("down_bin", bo4, 15);
        chk("down_gray", go4, 8);
        chk("down_wrap", wr4, 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("down2_bin", bo4, 14);
        chk("down2_gray", go4, 9);
        chk("down2_wrap", wr4, 0);

        for (int i = 0; i < 6; i++) drive(0, 1, i[0], 0, 0, 0, 0);

        drive(0, 1, 1, 1, 10, 0, 0);
        chk("load_bin", bo4, 10);
        chk("load_gray", go4, 15);
        chk("load_wrap", wr4, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 3, 0, 0);
            chk("hold_bin", bo4, 10);
        end
        drive(0, 0, 1, 1, 255, 0, 0);
        drive(0, 1, 1, 1, 255, 0, 0);
        chk("load_max_wrap", wr4, 0);

        // converter over every 8-bit code, counter busy alongside
        for (int i = 0; i < 256; i++) begin
            drive(0, 1, i[2], 0, 0, 1, i ^ (i >> 1));
            chk("conv_bvalid", bv4, 1);
            if (i < 16) chk("conv_w4", bc4, i);
            if (i == 9) chk("conv_1101", bc4, 9);
            chk("conv_w8", bc8, i);
        end
        drive(0, 0, 1, 0, 0, 0, 6);
        chk("conv_idle_bvalid", bv4, 0);
        chk("conv_hold", bc8, 255);

        drive(0, 1, 1, 0, 0, 1, 13);
        drive(1, 1, 1, 1, 7, 1, 13);
        chk("rst_mid_bin", bo4, 0);
        chk("rst_mid_gray", go4, 0);
        chk("rst_mid_conv", bc4, 0);
        chk("rst_mid_bvalid", bv4, 0);
        chk("rst_mid_wrap", wr4, 0);

        drive(0, 1, 0, 0, 0, 0, 0);
        chk("post_rst_down_bin", bo4, 15);
        chk("post_rst_down_wrap", wr4, 1);

        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 40) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 1), $urandom);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
